num_ctrl_osc: RTL and testbench



---
 rtl/num_ctrl_osc_pkg.sv | 22 ++
 rtl/num_ctrl_osc_pulse_sync.sv | 26 ++
 rtl/num_ctrl_osc.sv | 109 ++++++++++
 tb/tb_num_ctrl_osc.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/num_ctrl_osc_pkg.sv
// Shared encodings and default parameters for the digitally controlled oscillator.
package num_ctrl_osc_pkg;

    localparam int DEF_DIV         = 16;
    localparam int DEF_CW          = 5;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STAT_W      = 8;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_ADV  = 2'd1,
        P_RET  = 2'd2
    } pend_t;

    // Encodings line up with pend_t so a pending request commits by a plain cast.
    typedef enum logic [1:0] {
        C_NONE = 2'd0,
        C_ADV  = 2'd1,
        C_RET  = 2'd2
    } commit_t;

endpackage

// File: rtl/num_ctrl_osc_pulse_sync.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
module pulse_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_high,
    input  logic rst,
    input  logic async_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_high or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            edge_out <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q   <= sync_q[SYNC_STAGES-1];
            edge_out <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/num_ctrl_osc.sv
// DCO: divides clk_high by DIV, stretching or shrinking one low phase per
// period on synchronized ahead/behind requests from the loop filter.
module num_ctrl_osc
    import num_ctrl_osc_pkg::*;
#(
    parameter int DIV         = DEF_DIV,
    parameter int CW          = DEF_CW,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STAT_W      = DEF_STAT_W
) (
    input  logic              clk_high,
    input  logic              rst,
    input  logic              ahead_in,
    input  logic              behind_in,
    output logic              clk_out,
    output logic              sample_pulse,
    output logic [STAT_W-1:0] adv_cnt,
    output logic [STAT_W-1:0] ret_cnt
);

    localparam logic [CW-1:0] HALF     = CW'(DIV / 2);
    localparam logic [CW-1:0] TERM_NOM = CW'(DIV - 1);
    localparam logic [CW-1:0] TERM_ADV = CW'(DIV - 2);
    localparam logic [CW-1:0] TERM_RET = CW'(DIV);

    logic          ahead_edge;
    logic          behind_edge;
    logic [CW-1:0] cnt;
    logic [CW-1:0] term;
    pend_t         pend;
    commit_t       commit;

    pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ahead (
        .clk_high (clk_high),
        .rst      (rst),
        .async_in (ahead_in),
        .edge_out (ahead_edge)
    );

    pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_behind (
        .clk_high (clk_high),
        .rst      (rst),
        .async_in (behind_in),
        .edge_out (behind_edge)
    );

    // Opposite request cancels; simultaneous edges are treated as noise.
    function automatic pend_t next_pend(pend_t cur, logic a, logic b);
        pend_t nxt;
        nxt = cur;
        if (a && !b) begin
            case (cur)
                P_IDLE:  nxt = P_ADV;
                P_RET:   nxt = P_IDLE;
                default: nxt = cur;
            endcase
        end else if (b && !a) begin
            case (cur)
                P_IDLE:  nxt = P_RET;
                P_ADV:   nxt = P_IDLE;
                default: nxt = cur;
            endcase
        end
        return nxt;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        term = TERM_NOM;
        case (commit)
            C_ADV:   term = TERM_ADV;
            C_RET:   term = TERM_RET;
            default: term = TERM_NOM;
        endcase
    end

    always_ff @(posedge clk_high or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            pend         <= P_IDLE;
            commit       <= C_NONE;
            clk_out      <= 1'b0;
            sample_pulse <= 1'b0;
            adv_cnt      <= '0;
            ret_cnt      <= '0;
        end else begin
            clk_out      <= (cnt < HALF);
            sample_pulse <= (cnt == HALF);
            cnt          <= (cnt == term) ? '0 : cnt + 1'b1;
            if (cnt == term)
                commit <= C_NONE;
            // Commit point: an edge landing here starts the next period's request.
            if (cnt == HALF) begin
                commit <= commit_t'(pend);
                pend   <= next_pend(P_IDLE, ahead_edge, behind_edge);
                if (pend == P_ADV)
                    adv_cnt <= sat_inc(adv_cnt);
                if (pend == P_RET)
                    ret_cnt <= sat_inc(ret_cnt);
            end else begin
                pend <= next_pend(pend, ahead_edge, behind_edge);
            end
        end
    end

endmodule

// File: tb/tb_num_ctrl_osc.sv
// Directed bench for num_ctrl_osc: period/phase/strobe and statistics checks.
module tb_num_ctrl_osc;

    logic       clk_high = 1'b0;
    logic       rst;
    logic       ahead_in;
    logic       behind_in;
    logic       clk_out;
    logic       sample_pulse;
    logic [7:0] adv_cnt;
    logic [7:0] ret_cnt;

    int checks = 0;
    int errors = 0;
    int exp_adv = 0;
    int exp_ret = 0;

    num_ctrl_osc dut (
        .clk_high     (clk_high),
        .rst          (rst),
        .ahead_in     (ahead_in),
        .behind_in    (behind_in),
        .clk_out      (clk_out),
        .sample_pulse (sample_pulse),
        .adv_cnt      (adv_cnt),
        .ret_cnt      (ret_cnt)
    );

    always #5 clk_high = ~clk_high;

    // kind: 0 none, 1 ahead, 2 behind, 3 both together, 4 ahead then behind
    typedef struct {
        int kind;
        int r;
        int per0;
        int per1;
        int dadv;
        int dret;
    } vec_t;

    vec_t vecs[8];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns at the negedge where clk_out is first seen high (cnt == 1).
    task automatic wait_rise();
        logic prev;
        bit   ok;
        prev = clk_out;
        ok   = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_high);
            if (!prev && clk_out) begin
                ok = 1;
                break;
            end
            prev = clk_out;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_rise: got no clk_out rise expected rise within 64 cycles");
        end
    endtask

    // Called at a rise negedge; returns at the next rise negedge.
    task automatic measure(output int per, output int hi, output int sp);
        logic prev;
        per  = 0;
        hi   = 1;
        sp   = 0;
        prev = 1'b1;
        while (per < 64) begin
            @(negedge clk_high);
            per++;
            if (clk_out && !prev) break;
            if (clk_out) hi++;
            if (sample_pulse) sp++;
            prev = clk_out;
        end
    endtask

    // Called at cnt == 1; raises the chosen input(s) at cnt == r for 3 cycles.
    task automatic drive(int kind, int r);
        repeat (r - 1) @(negedge clk_high);
        case (kind)
            1: ahead_in = 1'b1;
            2: behind_in = 1'b1;
            3: begin ahead_in = 1'b1; behind_in = 1'b1; end
            4: ahead_in = 1'b1;
            default: ;
        endcase
        repeat (3) @(negedge clk_high);
        ahead_in  = 1'b0;
        behind_in = 1'b0;
        if (kind == 4) begin
            behind_in = 1'b1;
            repeat (3) @(negedge clk_high);
            behind_in = 1'b0;
        end
    endtask

    initial begin
        int per0, hi0, sp0, per1, hi1, sp1, bad;

        vecs[0] = '{0, 1, 16, 16, 0, 0};
        vecs[1] = '{1, 1, 15, 16, 1, 0};
        vecs[2] = '{2, 1, 17, 16, 0, 1};
        vecs[3] = '{2, 9, 16, 17, 0, 1};
        vecs[4] = '{4, 1, 16, 16, 0, 0};
        vecs[5] = '{3, 2, 16, 16, 0, 0};
        vecs[6] = '{1, 4, 15, 16, 1, 0};
        vecs[7] = '{1, 5, 16, 15, 1, 0};

        rst       = 1'b1;
        ahead_in  = 1'b0;
        behind_in = 1'b0;
        repeat (3) @(negedge clk_high);
        check("reset clk_out", int'(clk_out), 0);
        check("reset sample_pulse", int'(sample_pulse), 0);
        check("reset adv_cnt", int'(adv_cnt), 0);
        check("reset ret_cnt", int'(ret_cnt), 0);
        rst = 1'b0;

        wait_rise();
        measure(per0, hi0, sp0);
        check("nominal period", per0, 16);
        check("nominal high", hi0, 8);
        check("nominal strobes", sp0, 1);

        for (int v = 0; v < 8; v++) begin
            wait_rise();
            fork
                drive(vecs[v].kind, vecs[v].r);
                begin
                    measure(per0, hi0, sp0);
                    measure(per1, hi1, sp1);
                end
            join
            exp_adv += vecs[v].dadv;
            exp_ret += vecs[v].dret;
            check($sformatf("vec%0d period0", v), per0, vecs[v].per0);
            check($sformatf("vec%0d high0", v), hi0, 8);
            check($sformatf("vec%0d strobe0", v), sp0, 1);
            check($sformatf("vec%0d period1", v), per1, vecs[v].per1);
            check($sformatf("vec%0d adv_cnt", v), int'(adv_cnt), exp_adv);
            check($sformatf("vec%0d ret_cnt", v), int'(ret_cnt), exp_ret);
        end

        // Continuous advance: every period shortened, statistics saturate.
        wait_rise();
        bad = 0;
        for (int p = 0; p < 300; p++) begin
            fork
                drive(1, 1);
                measure(per0, hi0, sp0);
            join
            if (per0 != 15 || hi0 != 8 || sp0 != 1) bad++;
        end
        exp_adv = (exp_adv + 300 > 255) ? 255 : exp_adv + 300;
        check("sat bad periods", bad, 0);
        check("sat adv_cnt", int'(adv_cnt), exp_adv);
        check("sat ret_cnt", int'(ret_cnt), exp_ret);

        // Asynchronous reset mid-period, while clk_out is high.
        wait_rise();
        repeat (4) @(negedge clk_high);
        check("pre-reset clk_out", int'(clk_out), 1);
        rst = 1'b1;
        #1;
        check("async clk_out", int'(clk_out), 0);
        check("async sample_pulse", int'(sample_pulse), 0);
        check("async adv_cnt", int'(adv_cnt), 0);
        check("async ret_cnt", int'(ret_cnt), 0);
        repeat (2) @(negedge clk_high);
        rst = 1'b0;
        wait_rise();
        measure(per0, hi0, sp0);
        check("post-reset period", per0, 16);
        check("post-reset high", hi0, 8);
        check("post-reset strobes", sp0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
